// File: rtl/async_fifo_wptr_full.sv
// Write-domain pointer/status stage of a dual-clock FIFO: binary and Gray write
// pointers, RAM write strobe, and registered full/almost-full/occupancy/overflow.
module async_fifo_wptr_full #(
  parameter int ASIZE        = 4,
  parameter int AFULL_THRESH = 14
) (
  input  logic             wr_clk,
  input  logic             wr_rst,
  input  logic             winc,
  input  logic [ASIZE:0]   wq2_rptr,
  input  logic             ovf_clr,
  output logic             wclken,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr,
  output logic             wfull,
  output logic             wafull,
  output logic [ASIZE:0]   wcount,
  output logic             wovf
);

  localparam logic [ASIZE:0] AFULL_LVL = AFULL_THRESH[ASIZE:0];

  logic [ASIZE:0] wbin;
  logic [ASIZE:0] wbin_next;
  logic [ASIZE:0] wgray_next;
  logic [ASIZE:0] rbin;
  logic [ASIZE:0] wcount_next;
  logic           wfull_next;
  logic           wafull_next;

  assign wclken = winc & ~wfull;
  assign waddr  = wbin[ASIZE-1:0];

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    rbin        = '0;
    rbin[ASIZE] = wq2_rptr[ASIZE];
    for (int i = ASIZE - 1; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ wq2_rptr[i];
    end
  end

  assign wbin_next   = wbin + {{ASIZE{1'b0}}, wclken};
  assign wgray_next  = wbin_next ^ (wbin_next >> 1);
  assign wcount_next = wbin_next - rbin;

  // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
  assign wfull_next  = (wgray_next == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]});
  assign wafull_next = (wcount_next >= AFULL_LVL);

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wbin   <= '0;
      wptr   <= '0;
      wfull  <= 1'b0;
      wafull <= 1'b0;
      wcount <= '0;
      wovf   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      wbin   <= wbin_next;
      wptr   <= wgray_next;
      wfull  <= wfull_next;
      wafull <= wafull_next;
      wcount <= wcount_next;
      // A new overflow outranks a simultaneous clear so no event is lost.
      if (winc && wfull) begin
        wovf <= 1'b1;
      end else if (ovf_clr) begin
        wovf <= 1'b0;
      end
    end
  end

endmodule

// File: doc/async_fifo_wptr_full.md
# async_fifo_wptr_full

Write-domain pointer and status stage of the dual-clock FIFO. It keeps the binary and Gray write pointers, drives the RAM write address and enable, and publishes the Gray write pointer that the read domain's `sync_ptr` instance samples. It consumes the read pointer after that pointer has been synchronized into the write clock by the companion `sync_ptr`. From these it produces registered full, almost-full, occupancy and sticky-overflow status.

## Interface
- `ASIZE`, 4 — address width. FIFO depth is 2^ASIZE. ASIZE ≥ 2 is required.
- `AFULL_THRESH`, 14 — occupancy at or above which `wafull` asserts. Legal range is 1..2^ASIZE.
- `wr_clk`  in  1  write-domain clock. It is the only clock in this block.
- `wr_rst`  in  1  asynchronous, active-high reset, released synchronously to `wr_clk` upstream.
- `winc`  in  1  write request from the producer.
- `wq2_rptr`  in  ASIZE+1  Gray read pointer, already synchronized into `wr_clk`.
- `ovf_clr`  in  1  clears `wovf`.
- `wclken`  out  1  RAM write enable, equal to `winc & ~wfull` (combinational).
- `waddr`  out  ASIZE  RAM write address, equal to the low ASIZE bits of the binary pointer.
- `wptr`  out  ASIZE+1  registered Gray write pointer. Routed to `src_ptr` of the read-side synchronizer.
- `wfull`  out  1  registered full flag.
- `wafull`  out  1  registered almost-full flag.
- `wcount`  out  ASIZE+1  registered occupancy as seen from the write side, range 0..2^ASIZE.
- `wovf`  out  1  sticky overflow flag.

## Operation
- **State:** `wbin` (ASIZE+1 binary), `wptr` (Gray), `wfull`, `wafull`, `wcount`, `wovf`.
- **Pointer advance:** `wbin_next = wbin + (winc & ~wfull)`, modulo 2^(ASIZE+1).
  - `wgray_next = wbin_next ^ (wbin_next >> 1)`.
  - `wptr` changes by exactly one bit per accepted write and never changes on any other cycle.
- **Read pointer conversion:** `rbin = gray2bin(wq2_rptr)` using the XOR prefix from the MSB down. This path is combinational.
- **Full:** `wfull_next = (wgray_next == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]})`.
- **Occupancy:** `wcount_next = wbin_next - rbin`, modulo 2^(ASIZE+1).
  - `wfull_next` is 1 exactly when `wcount_next == 2^ASIZE`.
- **Almost-full:** `wafull_next = (wcount_next >= AFULL_THRESH)`.
- **Overflow:**
  - Set when `winc & wfull`.
  - Cleared by `ovf_clr`.
  - If set and clear occur in the same cycle, set wins.
- **Write while full:** the write is dropped. `wclken` = 0, and `wbin`, `wptr` and `waddr` are unchanged.
- **Pessimistic status:** `wfull`, `wafull` and `wcount` are conservative, because the read pointer is seen late.
  - They may report full for extra cycles.
  - They never report free space that does not exist.
- **Reset:** asserting `wr_rst` at any time, including mid-burst, asynchronously clears every register.
  - Resulting values: `wbin` = 0, `wptr` = 0, `waddr` = 0, `wfull` = 0, `wafull` = 0, `wcount` = 0, `wovf` = 0.
  - The read domain must be reset in the same window. The block does not handle a one-sided reset.
- **Wrap-around:** the pointer MSB toggles every 2^ASIZE writes. Full/empty discrimination relies on this extra bit. No special casing is needed at the wrap.

## Timing
- **Write acceptance:** a write is accepted in a cycle where `winc` = 1 and `wfull` = 0 at the rising edge. `wclken` is high in that same cycle and `waddr` holds the slot being written.
- **Pointer latency:** `wptr` and `waddr` reflect the write one cycle after acceptance.
- **Status latency:** `wfull`, `wafull` and `wcount` reflect the write one cycle after acceptance, with no additional lag.
- **Read-side lag:** a change on `wq2_rptr` appears in `wfull`, `wafull` and `wcount` one `wr_clk` edge later. The end-to-end lag from the read domain is therefore 2 read-pointer synchronizer flops plus 1.
- **`wovf` timing:** it sets on the edge following the offending cycle and clears on the edge following `ovf_clr`.
- **CDC constraint:** `wptr` comes straight from a flop, with no combinational logic after it, so it is safe for the downstream synchronizer.

## Test plan
- **Reset:** hold `wr_rst`=1 with random inputs toggling.
  - Required: every output is 0, except `wclken`, which follows `winc`.
  - Release reset and apply one write. Required: `wptr` = 5'b00001 and `waddr` = 1.
- **Fill:** `wq2_rptr` = 0, ASIZE = 4, `winc` held for 16 cycles.
  - Required: after the 16th write, `wfull` = 1, `wcount` = 16, `wptr` = 5'b11000.
  - Required: `wafull` rises the cycle `wcount` reaches 14.
- **Overflow:** from full, pulse `winc` for 3 cycles.
  - Required: `wclken` = 0, `wptr` unchanged, `wovf` = 1.
  - Assert `ovf_clr` and `winc` together. Required: `wovf` stays 1.
  - Then assert `ovf_clr` alone. Required: `wovf` = 0.
- **Drain release:** from full, step `wq2_rptr` to Gray 1 (5'b00001).
  - Required: the next edge gives `wfull` = 0 and `wcount` = 15.
  - A write in the following cycle is accepted, and `wfull` returns to 1.
- **Wrap:** perform 40 writes while `wq2_rptr` tracks `wptr` delayed by 3 cycles.
  - Required: `wptr` has a Hamming distance of 1 per write, `waddr` sequence is 0..15,0..15,0..7, and `wfull` is never asserted.
- **Mid-operation reset:** assert `wr_rst` asynchronously (between clock edges) at `wcount` = 9.
  - Required: all outputs are 0 immediately, without waiting for a clock edge.
  - Required: the first write after release goes to `waddr` = 0.
